osd_wr_arbiter: RTL and testbench
=================================

// Module: osd_wr_arbiter
// PURPOSE
//  Shares the OSD text-RAM write port between two requesters:
//   - req0: the NIOS II write vector ({vd_wrctrl, vd_wraddr, vd_wrdata}).
//   - req1: a hardware status-overlay updater.
//  Round-robin grant into a small FIFO; FIFO drained one write per cycle only while wr_allow is high.
//  Sits between the CPU subsystem and the OSD RAM in the 25 MHz domain; burst-limited so the RAM sees periodic idle cycles.
// PARAMETERS
//  FIFO_DEPTH_LOG2  2   FIFO depth = 2**FIFO_DEPTH_LOG2 entries (4)
//  ADDR_W          10   OSD RAM address width
//  DATA_W          13   OSD RAM data width
//  MAX_BURST        8   max consecutive writes before one forced idle cycle (1..255)
// PORTS
//  clk           in   1                  system clock (25 MHz domain)
//  rst           in   1                  asynchronous reset, active-high
//  flush         in   1                  synchronous FIFO clear
//  req0_valid    in   1                  requester 0 has a write
//  req0_ready    out  1                  requester 0 write accepted this cycle
//  req0_ctrl     in   2                  write control bits
//  req0_addr     in   ADDR_W             write address
//  req0_data     in   DATA_W             write data
//  req1_valid/req1_ready/req1_ctrl/req1_addr/req1_data   same as req0, for requester 1
//  wr_allow      in   1                  RAM port free for writes this cycle
//  vd_wren       out  1                  write strobe to OSD RAM
//  vd_wrctrl     out  2                  control of the issued write
//  vd_wraddr     out  ADDR_W             address of the issued write
//  vd_wrdata     out  DATA_W             data of the issued write
//  fifo_level    out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=1, async):
//   - Outputs: vd_wren=0; vd_wrctrl/vd_wraddr/vd_wrdata=0; fifo_level=0; req*_ready=0.
//   - Internal: pointers=0, last_grant=1 (so req0 wins first), burst_cnt=0, state=ST_IDLE.
//  Grant (combinational):
//   - Eligible when !full && !flush.
//   - One valid requester -> it is granted.
//   - Both valid -> grant the one != last_grant.
//   - req_i_ready = grant_i. A transfer is valid && ready.
//   - last_grant updates only on a transfer. Push {ctrl,addr,data} at the clock edge.
//  Requester rules:
//   - Fields are held stable while valid && !ready.
//   - The arbiter never accepts both requesters in one cycle.
//   - When full, ready=0 even if a pop occurs in the same cycle (no push-on-full bypass).
//  Drain FSM:
//   - ST_IDLE:  !empty && wr_allow -> pop; go to ST_BURST; burst_cnt=1.
//   - ST_BURST: pop while !empty && wr_allow && burst_cnt<MAX_BURST; burst_cnt++.
//     - empty or !wr_allow -> ST_IDLE; burst_cnt=0.
//     - burst_cnt==MAX_BURST -> ST_GAP, no pop.
//   - ST_GAP: exactly one cycle, no pop; burst_cnt=0; -> ST_IDLE.
//  Output timing:
//   - Outputs are registered. A pop in cycle N gives vd_wren=1 with that entry in cycle N+1; otherwise vd_wren=0 and data holds its last value.
//   - Accept-to-write latency: push in cycle N -> earliest pop N+1 -> vd_wren in N+2.
//  Simultaneous push+pop (not full): level unchanged; pointers wrap modulo depth.
//  Ordering: strict FIFO order across requesters; same-address writes land in accept order.
//  flush=1:
//   - ready=0; pointers and level cleared at the edge; state -> ST_IDLE; burst_cnt=0.
//   - vd_wren=0 next cycle. An entry popped in the flush cycle is discarded.
//  wr_allow dropping mid-burst: no pop that cycle; no entry lost.
//  fifo_level is registered, 0..2**FIFO_DEPTH_LOG2, and reflects post-edge occupancy.
// TESTING
//  T1 single: wr_allow=1; req0 {ctrl=2'b01, addr=10'h015, data=13'h0041} for one cycle
//     -> ready same cycle; vd_wren=1 two cycles later with same fields; level 0->1->0.
//  T2 round-robin: req0, req1 both valid continuously, wr_allow=0
//     -> accepted order r0,r1,r0,r1; FIFO fills to 4; both ready=0; level=4.
//  T3 backpressure: after T2, raise wr_allow
//     -> 4 writes in accept order on 4 consecutive cycles; re-grant resumes once not full.
//  T4 burst limit: wr_allow=1, req1 streaming 12 writes
//     -> 8 consecutive vd_wren, exactly one idle cycle, then the remaining writes; no loss.
//  T5 flush/reset: level=3, pulse flush
//     -> level=0 next cycle, vd_wren=0; assert rst mid-burst -> all outputs 0 immediately.
//  T6 wr_allow gaps: toggle wr_allow every cycle with 4 entries queued
//     -> vd_wren only one cycle after wr_allow=1 cycles; order preserved.

Source files
------------

// File: rtl/osd_wr_if.sv
// Bus bundle between the OSD write requesters, the arbiter and the RAM port.
// The master side is the requester/RAM environment; the slave side is the arbiter.
interface osd_wr_if #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 13,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                     flush;
  logic                     req0_valid;
  logic                     req0_ready;
  logic [1:0]               req0_ctrl;
  logic [ADDR_W-1:0]        req0_addr;
  logic [DATA_W-1:0]        req0_data;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [1:0]               req1_ctrl;
  logic [ADDR_W-1:0]        req1_addr;
  logic [DATA_W-1:0]        req1_data;
  logic                     wr_allow;
  logic                     vd_wren;
  logic [1:0]               vd_wrctrl;
  logic [ADDR_W-1:0]        vd_wraddr;
  logic [DATA_W-1:0]        vd_wrdata;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;

  modport master (
    output flush,
    output req0_valid, req0_ctrl, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_addr, req1_data,
    input  req1_ready,
    output wr_allow,
    input  vd_wren, vd_wrctrl, vd_wraddr, vd_wrdata,
    input  fifo_level
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_ctrl, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_addr, req1_data,
    output req1_ready,
    input  wr_allow,
    output vd_wren, vd_wrctrl, vd_wraddr, vd_wrdata,
    output fifo_level
  );
endinterface

// File: rtl/osd_wr_arbiter.sv
// Round-robin arbiter sharing the OSD text-RAM write port between two requesters.
// Accepted writes queue in a small FIFO drained in bursts capped by MAX_BURST.
module osd_wr_arbiter #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 13,
  parameter int MAX_BURST       = 8
) (
  input  logic     clk,
  input  logic     rst,
  osd_wr_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam int EW    = 2 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP
  } state_t;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_last;
  state_t            r_state;
  logic [7:0]        r_burst_cnt;
  logic              r_wren;
  logic [1:0]        r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic          w_full;
  logic          w_empty;
  logic          w_elig;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_push;
  logic [EW-1:0] w_din;
  logic          w_can_pop;
  logic          w_pop;
  logic [7:0]    w_cnt_nxt;
  logic [7:0]    w_max;

  assign w_max     = 8'(MAX_BURST);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_elig    = !w_full && !bus.flush && !rst;

  // r_last=1 means req1 won last, so req0 has priority on a tie
  assign w_gnt0 = w_elig && bus.req0_valid
               && (!bus.req1_valid || r_last);
  assign w_gnt1 = w_elig && bus.req1_valid
               && (!bus.req0_valid || !r_last);
  assign w_push = w_gnt0 || w_gnt1;

  assign w_din = w_gnt0
    ? {bus.req0_ctrl, bus.req0_addr, bus.req0_data}
    : {bus.req1_ctrl, bus.req1_addr, bus.req1_data};

  assign w_can_pop = !w_empty && bus.wr_allow && !bus.flush;
  assign w_cnt_nxt = r_burst_cnt + 8'd1;

  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_pop = w_can_pop;
      ST_BURST: w_pop = w_can_pop && (r_burst_cnt < w_max);
      default:  w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_last      <= 1'b1;
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_wren      <= 1'b0;
      r_ctrl      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_wren <= w_pop;
      if (w_pop) begin
        {r_ctrl, r_addr, r_data} <= r_mem[r_rd_ptr];
      end
      if (w_push) r_last <= w_gnt1;
      if (bus.flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_level     <= '0;
        r_state     <= ST_IDLE;
        r_burst_cnt <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
        // the pop that reaches MAX_BURST goes straight to the idle slot
        if (w_pop) begin
          r_burst_cnt <= w_cnt_nxt;
          r_state     <= (w_cnt_nxt >= w_max) ? ST_GAP : ST_BURST;
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              r_burst_cnt <= '0;
            end
            ST_BURST: begin
              r_state     <= (r_burst_cnt >= w_max) ? ST_GAP : ST_IDLE;
              r_burst_cnt <= (r_burst_cnt >= w_max) ? r_burst_cnt : 8'd0;
            end
            default: begin
              r_state     <= ST_IDLE;
              r_burst_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.vd_wren    = r_wren;
  assign bus.vd_wrctrl  = r_ctrl;
  assign bus.vd_wraddr  = r_addr;
  assign bus.vd_wrdata  = r_data;
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Bench for osd_wr_arbiter: directed table, corner sequences and random
// traffic against a queue-based model of the arbiter.
module tb_osd_wr_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 13;
  localparam int DL   = 2;
  localparam int DEP  = 4;
  localparam int MAXB = 8;

  typedef logic [2+AW+DW-1:0] ent_t;

  typedef struct {
    bit v0, v1, wa, fl;
    bit r0, r1, wren;
    int lvl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_wr_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH_LOG2(DL)) bus ();

  osd_wr_arbiter #(
    .FIFO_DEPTH_LOG2(DL),
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  ent_t q[$];
  bit   m_last;
  int   m_run;
  bit   m_gap;
  bit   m_wren;
  ent_t m_out;
  bit   last_g0, last_g1;
  bit   obs_r0, obs_r1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.vd_wren, bus.vd_wrctrl, bus.vd_wraddr,
            bus.vd_wrdata, bus.fifo_level};
  endfunction

  task automatic new_fields(int which);
    if (which == 0) begin
      bus.req0_ctrl = 2'($urandom);
      bus.req0_addr = AW'($urandom);
      bus.req0_data = DW'($urandom);
    end else begin
      bus.req1_ctrl = 2'($urandom);
      bus.req1_addr = AW'($urandom);
      bus.req1_data = DW'($urandom);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last  = 1'b1;
    m_run   = 0;
    m_gap   = 1'b0;
    m_wren  = 1'b0;
    m_out   = '0;
    last_g0 = 1'b0;
    last_g1 = 1'b0;
  endtask

  // Called at posedge+1; inputs already driven for this cycle.
  task automatic tick(string nm);
    bit g0, g1, elig, pop;
    #3;
    elig = !bus.flush && (q.size() < DEP);
    g0 = elig && bus.req0_valid && (!bus.req1_valid || m_last);
    g1 = elig && bus.req1_valid && (!bus.req0_valid || !m_last);
    obs_r0 = bus.req0_ready;
    obs_r1 = bus.req1_ready;
    chk({nm, "_ready"}, {obs_r0, obs_r1}, {g0, g1});
    pop = !bus.flush && bus.wr_allow && (q.size() > 0) && !m_gap;
    if (m_gap) begin
      m_gap = 1'b0;
      m_run = 0;
    end else if (pop) begin
      m_run++;
      if (m_run == MAXB) begin
        m_gap = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_wren = pop;
    if (pop) m_out = q.pop_front();
    if (g0) begin
      q.push_back({bus.req0_ctrl, bus.req0_addr, bus.req0_data});
      m_last = 1'b0;
    end else if (g1) begin
      q.push_back({bus.req1_ctrl, bus.req1_addr, bus.req1_data});
      m_last = 1'b1;
    end
    if (bus.flush) begin
      q.delete();
      m_run = 0;
      m_gap = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({nm, "_out"}, outs(), {m_wren, m_out, 3'(q.size())});
    last_g0 = g0;
    last_g1 = g1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.wr_allow   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #2;
    chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_out", outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  vec_t tbl[10];
  int   wr_idx[$];
  int   sent;
  int   nwr;

  initial begin
    idle_inputs();
    new_fields(0);
    new_fields(1);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single write from req0
    bus.wr_allow   = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_ctrl  = 2'b01;
    bus.req0_addr  = 10'h015;
    bus.req0_data  = 13'h0041;
    tick("t1a");
    chk("t1_ready", obs_r0, 1);
    chk("t1_lvl1", bus.fifo_level, 1);
    bus.req0_valid = 1'b0;
    tick("t1b");
    chk("t1_write", outs(), {1'b1, 2'b01, 10'h015, 13'h0041, 3'd0});
    tick("t1c");
    chk("t1_idle", bus.vd_wren, 0);

    // round-robin fill then backpressure release
    do_reset();
    tbl[0] = '{1, 1, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 0, 0, 1, 0, 2};
    tbl[2] = '{1, 1, 0, 0, 1, 0, 0, 3};
    tbl[3] = '{1, 1, 0, 0, 0, 1, 0, 4};
    tbl[4] = '{1, 1, 0, 0, 0, 0, 0, 4};
    tbl[5] = '{1, 1, 1, 0, 0, 0, 1, 3};
    tbl[6] = '{1, 1, 1, 0, 1, 0, 1, 3};
    tbl[7] = '{1, 1, 1, 0, 0, 1, 1, 3};
    tbl[8] = '{1, 1, 1, 0, 1, 0, 1, 3};
    tbl[9] = '{0, 0, 1, 0, 0, 0, 1, 2};
    for (int i = 0; i < 10; i++) begin
      bus.req0_valid = tbl[i].v0;
      bus.req1_valid = tbl[i].v1;
      bus.wr_allow   = tbl[i].wa;
      bus.flush      = tbl[i].fl;
      tick("tbl");
      chk($sformatf("tbl%0d_ready", i), {obs_r0, obs_r1},
          {tbl[i].r0, tbl[i].r1});
      chk($sformatf("tbl%0d_out", i), {bus.vd_wren, bus.fifo_level},
          {tbl[i].wren, 3'(tbl[i].lvl)});
      if (last_g0) new_fields(0);
      if (last_g1) new_fields(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("t3_drain");
    chk("t3_empty", bus.fifo_level, 0);

    // burst limit with req1 streaming 12 writes
    do_reset();
    bus.wr_allow   = 1'b1;
    bus.req1_valid = 1'b1;
    new_fields(1);
    sent = 0;
    wr_idx.delete();
    for (int c = 0; c < 40; c++) begin
      tick("t4");
      if (bus.vd_wren) wr_idx.push_back(c);
      if (last_g1) begin
        sent++;
        new_fields(1);
        if (sent == 12) bus.req1_valid = 1'b0;
      end
    end
    nwr = wr_idx.size();
    chk("t4_count", nwr, 12);
    if (nwr == 12) begin
      chk("t4_burst8", wr_idx[7] - wr_idx[0], 7);
      chk("t4_gap1", wr_idx[8] - wr_idx[7], 2);
      chk("t4_tail", wr_idx[11] - wr_idx[8], 3);
    end

    // flush with three queued, pop attempt discarded
    do_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_fields(0);
      tick("t5_fill");
    end
    chk("t5_lvl3", bus.fifo_level, 3);
    new_fields(0);
    bus.flush    = 1'b1;
    bus.wr_allow = 1'b1;
    tick("t5_flush");
    chk("t5_flush_ready", obs_r0, 0);
    chk("t5_flush_out", {bus.vd_wren, bus.fifo_level}, 0);
    bus.flush      = 1'b0;
    bus.wr_allow   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      new_fields(0);
      tick("t5_refill");
    end
    bus.req0_valid = 1'b0;
    bus.wr_allow   = 1'b1;
    tick("t5_b0");
    tick("t5_b1");
    chk("t5_midburst", bus.vd_wren, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_rst", outs(), 0);
    do_reset();

    // wr_allow toggling with four entries queued
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("t6_fill");
      if (last_g0) new_fields(0);
      if (last_g1) new_fields(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      bus.wr_allow = (i % 2 == 0);
      tick("t6");
      if (bus.vd_wren) nwr++;
    end
    chk("t6_writes", nwr, 4);

    // random traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!bus.req0_valid || last_g0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        new_fields(0);
      end
      if (!bus.req1_valid || last_g1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        new_fields(1);
        if ($urandom_range(0, 3) == 0) bus.req1_addr = bus.req0_addr;
      end
      bus.wr_allow = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 40) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
